// File: rtl/wb_spi_xbar_pkg.sv
// ---------------------------------------------------------------------------
// wb_spi_xbar_pkg
// Shared definitions for the Wishbone single-host / multi-slave decoder that
// sits behind the SPI-to-Wishbone bridge: bus widths, the window-select bit
// positions inside the host address, the default error read pattern, the
// watchdog counter width and the decoder FSM state type.
// ---------------------------------------------------------------------------
package wb_spi_xbar_pkg;

   localparam int WB_ADR_W = 22;
   localparam int WB_DAT_W = 32;
   localparam int WIN_MSB  = 21;
   localparam int WIN_LSB  = 20;
   localparam int WDOG_W   = 16;

   // Pattern returned to the host on any error completion, chosen so that a
   // failed read is easy to spot in an SPI trace.
   localparam logic [WB_DAT_W-1:0] DEFAULT_ERR_DATA = 32'hBADACCE5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      ACK  = 2'd2
   } xbar_state_t;

endpackage

// File: rtl/wb_xbar_watchdog.sv
// ---------------------------------------------------------------------------
// wb_xbar_watchdog
// Saturating cycle counter that measures how long a slave access has been
// outstanding and raises a timeout strobe once the limit is reached.
//
// Ports:
//   wb_clk_i   clock
//   wb_rst_ni  asynchronous active-low reset
//   clear      restart the count from zero (new access accepted)
//   enable     count this cycle (access outstanding)
//   timeout    high while the count equals TIMEOUT_CYCLES-1
// ---------------------------------------------------------------------------
module wb_xbar_watchdog
   import wb_spi_xbar_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1023
) (
   input  logic wb_clk_i,
   input  logic wb_rst_ni,
   input  logic clear,
   input  logic enable,
   output logic timeout
);

   logic [WDOG_W-1:0] count;

   // The counter parks at all-ones rather than wrapping, so a stuck access
   // can never alias back onto a small count and skip its timeout.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && (count != {WDOG_W{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

   // Count is zero in the first outstanding cycle, so this fires in the
   // TIMEOUT_CYCLES-th cycle of the access.
   assign timeout = (count == WDOG_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/wb_spi_xbar.sv
// ---------------------------------------------------------------------------
// wb_spi_xbar
// Wishbone single-host decoder for up to four slave windows selected by
// wb_adr_i[21:20]. One access is outstanding at a time. Every host access
// is guaranteed to complete: unmapped windows and slaves that never ack
// (watchdog timeout) complete with ERR_DATA.
//
// Ports:
//   wb_clk_i, wb_rst_ni             clock, async active-low reset
//   wb_cyc_i/stb_i/we_i/adr_i/sel_i/dat_i   host request
//   wb_ack_o, wb_dat_o              registered single-cycle ack + read data
//   s_cyc_o, s_stb_o                per-slave cycle/strobe (identical)
//   s_we_o, s_adr_o, s_sel_o, s_dat_o   shared registered request copy
//   s_dat_i, s_ack_i                per-slave read data (slave n at [32n+:32])
//                                   and acks
//
// Optional feature (macro WB_SPI_XBAR_ERR_EN):
//   err_o       pulse coincident with an error wb_ack_o
//   err_cnt_o   saturating count of error completions
//   err_adr_o   address of the most recent error completion
// ---------------------------------------------------------------------------
module wb_spi_xbar
   import wb_spi_xbar_pkg::*;
#(
   parameter int                   NSLAVE         = 4,
   parameter int                   TIMEOUT_CYCLES = 1023,
   parameter logic [WB_DAT_W-1:0]  ERR_DATA       = DEFAULT_ERR_DATA
) (
   input  logic                       wb_clk_i,
   input  logic                       wb_rst_ni,
   input  logic                       wb_cyc_i,
   input  logic                       wb_stb_i,
   input  logic                       wb_we_i,
   input  logic [WB_ADR_W-1:0]        wb_adr_i,
   input  logic [3:0]                 wb_sel_i,
   input  logic [WB_DAT_W-1:0]        wb_dat_i,
   output logic                       wb_ack_o,
   output logic [WB_DAT_W-1:0]        wb_dat_o,
   output logic [NSLAVE-1:0]          s_cyc_o,
   output logic [NSLAVE-1:0]          s_stb_o,
   output logic                       s_we_o,
   output logic [WB_ADR_W-1:0]        s_adr_o,
   output logic [3:0]                 s_sel_o,
   output logic [WB_DAT_W-1:0]        s_dat_o,
   input  logic [NSLAVE*WB_DAT_W-1:0] s_dat_i,
   input  logic [NSLAVE-1:0]          s_ack_i
`ifdef WB_SPI_XBAR_ERR_EN
   ,
   output logic                       err_o,
   output logic [15:0]                err_cnt_o,
   output logic [WB_ADR_W-1:0]        err_adr_o
`endif
);

   xbar_state_t           state_q;
   xbar_state_t           state_d;
   logic [NSLAVE-1:0]     win_onehot;
   logic                  win_mapped;
   logic                  slave_ack;
   logic [WB_DAT_W-1:0]   slave_rdata;
   logic                  timeout;
   logic                  accept;
   logic                  finish_ok;
   logic                  finish_err;
   logic                  abort_req;

   // Decode the requested window into a one-hot slave select. Windows at or
   // above NSLAVE decode to all zeros and are treated as unmapped.
   always_comb begin
      win_onehot = '0;
      for (int n = 0; n < NSLAVE; n++) begin
         if (wb_adr_i[WIN_MSB:WIN_LSB] == 2'(n)) begin
            win_onehot[n] = 1'b1;
         end
      end
   end

   assign win_mapped = |win_onehot;

   // The active s_cyc_o bit doubles as the window select, so acks and read
   // data from any other slave are masked off here.
   assign slave_ack = |(s_ack_i & s_cyc_o);

   always_comb begin
      slave_rdata = '0;
      for (int n = 0; n < NSLAVE; n++) begin
         if (s_cyc_o[n]) begin
            slave_rdata = s_dat_i[WB_DAT_W*n +: WB_DAT_W];
         end
      end
   end

   // Next-state logic. A slave ack beats the timeout, which beats a host
   // abort. The !wb_ack_o term in IDLE keeps a host that still holds
   // cyc/stb for one cycle after its ack from starting a second access.
   always_comb begin
      state_d    = state_q;
      accept     = 1'b0;
      finish_ok  = 1'b0;
      finish_err = 1'b0;
      abort_req  = 1'b0;
      case (state_q)
         IDLE: begin
            if (wb_cyc_i && wb_stb_i && !wb_ack_o) begin
               accept = 1'b1;
               if (win_mapped) begin
                  state_d = BUSY;
               end else begin
                  finish_err = 1'b1;
                  state_d    = ACK;
               end
            end
         end
         BUSY: begin
            if (slave_ack) begin
               finish_ok = 1'b1;
               state_d   = ACK;
            end else if (timeout) begin
               finish_err = 1'b1;
               state_d    = ACK;
            end else if (!wb_cyc_i) begin
               abort_req = 1'b1;
               state_d   = IDLE;
            end
         end
         ACK: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register, shared request copy, slave cycle and host response.
   // The host ack is raised on the way out of ACK, so it lands one cycle
   // after the completion edge and overlaps the first IDLE cycle.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_q  <= IDLE;
         s_cyc_o  <= '0;
         s_we_o   <= 1'b0;
         s_adr_o  <= '0;
         s_sel_o  <= '0;
         s_dat_o  <= '0;
         wb_dat_o <= '0;
         wb_ack_o <= 1'b0;
      end else begin
         state_q  <= state_d;
         wb_ack_o <= (state_q == ACK);
         if (accept) begin
            s_we_o  <= wb_we_i;
            s_adr_o <= wb_adr_i;
            s_sel_o <= wb_sel_i;
            s_dat_o <= wb_dat_i;
            s_cyc_o <= win_onehot;
         end
         if (finish_ok || abort_req || (finish_err && (state_q == BUSY))) begin
            s_cyc_o <= '0;
         end
         if (finish_ok) begin
            wb_dat_o <= slave_rdata;
         end else if (finish_err) begin
            wb_dat_o <= ERR_DATA;
         end
      end
   end

   assign s_stb_o = s_cyc_o;

   wb_xbar_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .wb_clk_i  (wb_clk_i),
      .wb_rst_ni (wb_rst_ni),
      .clear     (accept),
      .enable    (state_q == BUSY),
      .timeout   (timeout)
   );

`ifdef WB_SPI_XBAR_ERR_EN
   logic err_pend_q;

   // Remember whether the pending completion is an error so the error
   // pulse, counter and address update line up with the host ack.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         err_pend_q <= 1'b0;
         err_o      <= 1'b0;
         err_cnt_o  <= '0;
         err_adr_o  <= '0;
      end else begin
         if (finish_ok) begin
            err_pend_q <= 1'b0;
         end else if (finish_err) begin
            err_pend_q <= 1'b1;
         end
         err_o <= (state_q == ACK) && err_pend_q;
         if ((state_q == ACK) && err_pend_q) begin
            err_adr_o <= s_adr_o;
            if (err_cnt_o != 16'hFFFF) begin
               err_cnt_o <= err_cnt_o + 16'd1;
            end
         end
      end
   end
`endif

endmodule
